// File: rtl/jtag_tap_if.sv
// Serial-side signal bundle of the jtag_tap controller: device pins plus the
// strobes and data lines shared with the downstream SIB/TDR network.
interface jtag_tap_if #(
  parameter int IR_WIDTH = 4
);
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic                net_tdi;
  logic                net_tdo;
  logic                shift;
  logic                capture;
  logic                update;
  logic                tlr;
  logic [IR_WIDTH-1:0] ir;

  modport master (
    input  tms, tdi, net_tdo,
    output tdo, tdo_en, net_tdi, shift, capture, update, tlr, ir
  );

  modport slave (
    output tms, tdi, net_tdo,
    input  tdo, tdo_en, net_tdi, shift, capture, update, tlr, ir
  );
endinterface

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller with IDCODE/BYPASS DRs that fronts a SIB/TDR network.
// Optional USERCODE DR is built when JTAG_TAP_USERCODE_EN is defined.
module jtag_tap #(
  parameter int                  IR_WIDTH       = 4,
  parameter logic [31:0]         IDCODE         = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE   = 4'b0001,
  parameter logic [IR_WIDTH-1:0] INSTR_NETWORK  = 4'b1000
`ifdef JTAG_TAP_USERCODE_EN
  ,
  parameter logic [31:0]         USERCODE       = 32'h0000_0000,
  parameter logic [IR_WIDTH-1:0] INSTR_USERCODE = 4'b0010
`endif
) (
  input  logic     tck,
  input  logic     trstb,
  jtag_tap_if.master bus
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,
    EXIT1_DR = 4'd5,
    PAUSE_DR = 4'd6,
    EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12,
    PAUSE_IR = 4'd13,
    EXIT2_IR = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS   = 2'd0,
    DR_IDCODE   = 2'd1,
    DR_NETWORK  = 2'd2,
    DR_USERCODE = 2'd3
  } dr_sel_t;

  tap_state_t          state_r;
  logic [IR_WIDTH-1:0] ir_r;
  logic [IR_WIDTH-1:0] ir_sr_r;
  logic [31:0]         idcode_sr_r;
  logic                bypass_r;
  logic                tdo_r;
  logic                tdo_en_r;
  logic                tdo_next_s;
  dr_sel_t             dr_sel_s;
`ifdef JTAG_TAP_USERCODE_EN
  logic [31:0]         usercode_sr_r;
`endif

  // TAP state machine, advanced by tms on rising tck
  always_ff @(posedge tck or negedge trstb) begin
    if (!trstb) begin
      state_r <= TLR;
    end else begin
      case (state_r)
        TLR:      state_r <= bus.tms ? TLR      : RTI;
        RTI:      state_r <= bus.tms ? SEL_DR   : RTI;
        SEL_DR:   state_r <= bus.tms ? SEL_IR   : CAP_DR;
        CAP_DR:   state_r <= bus.tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_r <= bus.tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_r <= bus.tms ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_r <= bus.tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_r <= bus.tms ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_r <= bus.tms ? SEL_DR   : RTI;
        SEL_IR:   state_r <= bus.tms ? TLR      : CAP_IR;
        CAP_IR:   state_r <= bus.tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_r <= bus.tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_r <= bus.tms ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_r <= bus.tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_r <= bus.tms ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_r <= bus.tms ? SEL_DR   : RTI;
        default:  state_r <= TLR;
      endcase
    end
  end

  // DR selection from the active instruction; unknown opcodes fall to BYPASS
  always_comb begin
    dr_sel_s = DR_BYPASS;
    if (ir_r == INSTR_IDCODE) begin
      dr_sel_s = DR_IDCODE;
    end else if (ir_r == INSTR_NETWORK) begin
      dr_sel_s = DR_NETWORK;
`ifdef JTAG_TAP_USERCODE_EN
    end else if (ir_r == INSTR_USERCODE) begin
      dr_sel_s = DR_USERCODE;
`endif
    end else begin
      dr_sel_s = DR_BYPASS;
    end
  end

  // Instruction and data shift registers on rising tck
  always_ff @(posedge tck or negedge trstb) begin
    if (!trstb) begin
      ir_r        <= INSTR_IDCODE;
      ir_sr_r     <= '0;
      idcode_sr_r <= 32'h0000_0000;
      bypass_r    <= 1'b0;
    end else begin
      if (state_r == TLR) begin
        ir_r <= INSTR_IDCODE;
      end else if (state_r == UPD_IR) begin
        ir_r <= ir_sr_r;
      end
      case (state_r)
        CAP_IR:   ir_sr_r <= IR_CAPTURE;
        SHIFT_IR: ir_sr_r <= {bus.tdi, ir_sr_r[IR_WIDTH-1:1]};
        default:  ir_sr_r <= ir_sr_r;
      endcase
      case (state_r)
        CAP_DR: begin
          if (dr_sel_s == DR_IDCODE) idcode_sr_r <= IDCODE;
          if (dr_sel_s == DR_BYPASS) bypass_r <= 1'b0;
        end
        SHIFT_DR: begin
          if (dr_sel_s == DR_IDCODE) idcode_sr_r <= {bus.tdi, idcode_sr_r[31:1]};
          if (dr_sel_s == DR_BYPASS) bypass_r <= bus.tdi;
        end
        default: begin
          idcode_sr_r <= idcode_sr_r;
          bypass_r    <= bypass_r;
        end
      endcase
    end
  end

`ifdef JTAG_TAP_USERCODE_EN
  // USERCODE data register, captured and shifted like IDCODE
  always_ff @(posedge tck or negedge trstb) begin
    if (!trstb) begin
      usercode_sr_r <= 32'h0000_0000;
    end else if (dr_sel_s == DR_USERCODE) begin
      case (state_r)
        CAP_DR:   usercode_sr_r <= USERCODE;
        SHIFT_DR: usercode_sr_r <= {bus.tdi, usercode_sr_r[31:1]};
        default:  usercode_sr_r <= usercode_sr_r;
      endcase
    end
  end
`endif

  // Serial output selection ahead of the falling-edge tdo flop
  always_comb begin
    tdo_next_s = 1'b0;
    case (state_r)
      SHIFT_IR: tdo_next_s = ir_sr_r[0];
      SHIFT_DR: begin
        case (dr_sel_s)
          DR_IDCODE:   tdo_next_s = idcode_sr_r[0];
          DR_NETWORK:  tdo_next_s = bus.net_tdo;
`ifdef JTAG_TAP_USERCODE_EN
          DR_USERCODE: tdo_next_s = usercode_sr_r[0];
`endif
          default:     tdo_next_s = bypass_r;
        endcase
      end
      default: tdo_next_s = 1'b0;
    endcase
  end

  // tdo and its enable change on falling tck so the host samples a stable bit
  always_ff @(negedge tck or negedge trstb) begin
    if (!trstb) begin
      tdo_r    <= 1'b0;
      tdo_en_r <= 1'b0;
    end else begin
      tdo_r    <= tdo_next_s;
      tdo_en_r <= (state_r == SHIFT_IR) || (state_r == SHIFT_DR);
    end
  end

  // Strobes decode straight from state so a trstb abort removes them at once
  assign bus.capture = (dr_sel_s == DR_NETWORK) && (state_r == CAP_DR);
  assign bus.shift   = (dr_sel_s == DR_NETWORK) && (state_r == SHIFT_DR);
  assign bus.update  = (dr_sel_s == DR_NETWORK) && (state_r == UPD_DR);
  assign bus.tlr     = (state_r == TLR);
  assign bus.ir      = ir_r;
  assign bus.net_tdi = bus.tdi;
  assign bus.tdo     = tdo_r;
  assign bus.tdo_en  = tdo_en_r;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed self-checking bench for jtag_tap: reset, IDCODE, IR scan, BYPASS,
// NETWORK strobes and trstb abort.
module tb_jtag_tap;

  logic tck;
  logic trstb;
  int   checks;
  int   errors;
  int   cap_cnt;
  int   sh_cnt;
  int   up_cnt;

  jtag_tap_if #(.IR_WIDTH(4)) bus ();

  jtag_tap dut (
    .tck   (tck),
    .trstb (trstb),
    .bus   (bus.master)
  );

  initial tck = 1'b0;
  always #10 tck = ~tck;

  // Count network strobes seen at each rising edge
  always @(posedge tck) begin
    cap_cnt <= cap_cnt + {31'd0, bus.capture};
    sh_cnt  <= sh_cnt + {31'd0, bus.shift};
    up_cnt  <= up_cnt + {31'd0, bus.update};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One tck: drive tms/tdi, then land just after the following falling edge
  task automatic tick(input logic tms_v, input logic tdi_v);
    bus.tms = tms_v;
    bus.tdi = tdi_v;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // From RTI: load an instruction, return to RTI; out holds captured IR bits
  task automatic ir_scan(input logic [3:0] val, output logic [3:0] out);
    out = 4'b0000;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      out[i] = bus.tdo;
      tick((i == 3), val[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: n-bit DR scan; nin is presented on net_tdo, one bit per shift
  task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] nin,
                         output logic [31:0] dout);
    dout = 32'h0000_0000;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    bus.net_tdo = nin[0];
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = bus.tdo;
      bus.net_tdo = (i + 1 < 32) ? nin[(i + 1) % 32] : 1'b0;
      tick((i == n - 1), din[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0]  irout;
    logic [31:0] dout;
    int          c0, s0, u0;

    checks      = 0;
    errors      = 0;
    cap_cnt     = 0;
    sh_cnt      = 0;
    up_cnt      = 0;
    trstb       = 1'b0;
    bus.tms     = 1'b1;
    bus.tdi     = 1'b0;
    bus.net_tdo = 1'b0;

    repeat (2) @(negedge tck);
    #1;
    check("rst_tlr", {31'd0, bus.tlr}, 32'd1);
    check("rst_ir", {28'd0, bus.ir}, 32'd1);
    check("rst_tdo", {31'd0, bus.tdo}, 32'd0);
    check("rst_tdo_en", {31'd0, bus.tdo_en}, 32'd0);
    trstb = 1'b1;

    repeat (5) tick(1'b1, 1'b0);
    check("tlr_after_5", {31'd0, bus.tlr}, 32'd1);
    check("ir_after_5", {28'd0, bus.ir}, 32'd1);
    tick(1'b0, 1'b0);
    check("rti_tlr_low", {31'd0, bus.tlr}, 32'd0);

    // IDCODE scan: no network strobes while IDCODE is selected
    c0 = cap_cnt; s0 = sh_cnt; u0 = up_cnt;
    dr_scan(32, 32'h0000_0000, 32'hFFFF_FFFF, dout);
    check("idcode_out", dout, 32'h1000_0001);
    check("idcode_no_cap", cap_cnt - c0, 32'd0);
    check("idcode_no_shift", sh_cnt - s0, 32'd0);
    check("idcode_no_upd", up_cnt - u0, 32'd0);
    check("tdo_en_idle", {31'd0, bus.tdo_en}, 32'd0);

    // IR capture pattern and all-ones instruction -> BYPASS
    ir_scan(4'b1111, irout);
    check("ir_capture", {30'd0, irout[1:0]}, 32'h1);
    check("ir_ones", {28'd0, bus.ir}, 32'hF);
    dr_scan(4, 32'h0000_0006, 32'h0000_000F, dout);
    check("bypass_ones", {28'd0, dout[3:0]}, 32'hC);

    // Five tms=1 from RTI reaches TLR and reloads IDCODE
    repeat (5) tick(1'b1, 1'b0);
    check("tlr_again", {31'd0, bus.tlr}, 32'd1);
    check("ir_reload", {28'd0, bus.ir}, 32'd1);
    tick(1'b0, 1'b0);

    // USERCODE opcode: 32-bit DR when enabled, BYPASS otherwise
    ir_scan(4'b0010, irout);
    check("ir_user", {28'd0, bus.ir}, 32'h2);
`ifdef JTAG_TAP_USERCODE_EN
    dr_scan(32, 32'h0000_0000, 32'hFFFF_FFFF, dout);
    check("usercode_out", dout, 32'h0000_0000);
`else
    dr_scan(4, 32'h0000_0006, 32'h0000_000F, dout);
    check("user_bypass", {28'd0, dout[3:0]}, 32'hC);
`endif

    // NETWORK: net_tdi follows tdi, strobe counts, tdo mirrors net_tdo
    bus.tdi = 1'b1;
    #1;
    check("net_tdi_1", {31'd0, bus.net_tdi}, 32'd1);
    bus.tdi = 1'b0;
    #1;
    check("net_tdi_0", {31'd0, bus.net_tdi}, 32'd0);
    ir_scan(4'b1000, irout);
    check("ir_net", {28'd0, bus.ir}, 32'h8);
    c0 = cap_cnt; s0 = sh_cnt; u0 = up_cnt;
    dr_scan(6, 32'h0000_0032, 32'h0000_002D, dout);
    check("net_tdo", {26'd0, dout[5:0]}, 32'h2D);
    check("net_cap", cap_cnt - c0, 32'd1);
    check("net_shift", sh_cnt - s0, 32'd6);
    check("net_upd", up_cnt - u0, 32'd1);

    // trstb abort in the middle of a NETWORK shift
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("abort_pre_shift", {31'd0, bus.shift}, 32'd1);
    u0 = up_cnt;
    trstb = 1'b0;
    #1;
    check("abort_shift", {31'd0, bus.shift}, 32'd0);
    check("abort_ir", {28'd0, bus.ir}, 32'd1);
    check("abort_tlr", {31'd0, bus.tlr}, 32'd1);
    @(negedge tck);
    #1;
    trstb = 1'b1;
    repeat (4) tick(1'b0, 1'b0);
    check("abort_no_upd", up_cnt - u0, 32'd0);
    check("abort_ir_after", {28'd0, bus.ir}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
